cgra_col_scheduler: RTL
=======================

# cgra_col_scheduler

Kernel-launch scheduler in front of the CGRA peripheral registers. Arbitrates round-robin among `N_REQ` launch requesters, each asking for a kernel ID and a column count. Allocates a contiguous block of free columns, first-fit from column 0, and drives the column request / kernel ID handshake toward the accelerator. On the accelerator's acknowledge it returns the granted column mask to the winning requester.

## Interface
Parameters:
- `N_COL`, 4, number of CGRA columns.
- `N_REQ`, 4, number of launch requesters.
- `KER_W`, 5, kernel ID width.
- `CNT_W`, `$clog2(N_COL+1)`, column-count width (derived, do not override).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  N_REQ  launch request per requester; level, held until `req_ready_o`.
- `req_ker_id_i`  in  N_REQ×KER_W  kernel ID per requester.
- `req_ncol_i`  in  N_REQ×CNT_W  columns needed per requester; legal range 1..N_COL.
- `req_ready_o`  out  N_REQ  one-hot, one-cycle completion pulse to the served requester.
- `req_cols_o`  out  N_COL  granted column mask; valid only while `req_ready_o` is nonzero.
- `req_err_o`  out  1  one-cycle pulse alongside `req_ready_o` when the request was rejected.
- `col_status_i`  in  N_COL  column occupancy; 1 = used.
- `acc_req_o`  out  N_COL  requested column mask toward the accelerator.
- `ker_id_o`  out  KER_W  kernel ID paired with `acc_req_o`.
- `acc_ack_i`  in  1  accelerator accepts the current request.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ALLOC, ISSUE, DONE.
- **IDLE**
  - If any `req_valid_i` is set, pick the first set bit at or after `rr_ptr`, wrapping.
  - Register the winner index, its kernel ID and its column count; go to ALLOC.
  - If no request is valid, stay in IDLE.
- **ALLOC**
  - If `req_valid_i[winner]` drops, abandon and go to IDLE; `rr_ptr` is unchanged.
  - If `ncol` is 0 or greater than N_COL, reject: `mask=0`, `err=1`, go to DONE.
  - Otherwise, search for the lowest start index s such that columns s..s+ncol-1 are all free in `col_status_i`, sampled this cycle.
  - If found, register the mask and go to ISSUE.
  - If not found, stay in ALLOC. The winner is held, with no bypass by other requesters, so wide requests cannot starve.
- **ISSUE**
  - Drive `acc_req_o=mask` and `ker_id_o=kid` from registers.
  - Hold them stable until `acc_ack_i` is high. On ack, go to DONE.
  - `req_valid_i` dropping in this state is ignored; the launch is committed.
- **DONE**
  - Pulse `req_ready_o[winner]=1`, `req_cols_o=mask`, `req_err_o=err`.
  - Set `rr_ptr = (winner+1) mod N_REQ`; go to IDLE.
- `acc_ack_i` outside ISSUE is ignored.
- `col_status_i` changing while in ISSUE does not alter the latched mask.
- Rejected requests never assert `acc_req_o`.

## Timing
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset (`rst_i` high at an edge): state=IDLE, `rr_ptr`=0, all outputs 0, `busy_o`=0.
  - Reset mid-ISSUE drops `acc_req_o` the next cycle; no `req_ready_o` pulse is produced.
- Minimum launch latency, with valid first seen in cycle 0:
  - ALLOC in cycle 1.
  - `acc_req_o` asserted in cycle 2.
  - Ack in cycle 2 gives `req_ready_o` in cycle 3.
  - `acc_req_o` is 0 in cycle 3.
- Back-to-back: the next request can enter ALLOC at cycle 5, giving one launch per 4 cycles.
- Rejection latency: `req_ready_o` and `req_err_o` assert 2 cycles after IDLE sampling.
- Simultaneous requests: only one is served per pass, and round-robin order is strict.

## Structure
- Shared package `cgra_pkg` holds `N_COL` and `KER_CONF_N_REG_LOG2` (the default source for `KER_W`).
- Add to `cgra_pkg`: `sched_state_e` enum {IDLE, ALLOC, ISSUE, DONE} and the `CNT_W` derivation.
- Sub-module `cgra_rr_arbiter` (combinational): inputs request vector and `rr_ptr`; outputs winner index and any-valid.
- The contiguous first-fit search stays inline: a loop over start index, at most N_COL candidates.

## Test plan
- **Single request:** req0 with ncol=2, kid=3, all columns free, ack in the first ISSUE cycle.
  - `acc_req_o=0011`, `ker_id_o=3` in cycle 2.
  - `req_ready_o=0001`, `req_cols_o=0011` in cycle 3.
- **Fragmentation:** `col_status_i=0101`, req1 ncol=2.
  - Stalls in ALLOC.
  - Set `col_status_i=0001` → `acc_req_o=0110`.
- **Round-robin:** req0..req3 all valid, ncol=1, immediate ack.
  - Service order 0,1,2,3,0.
  - `rr_ptr` wraps 3→0.
- **Reject:** ncol=0, then ncol=5.
  - Each gives `req_err_o=1` and `req_cols_o=0`.
  - `acc_req_o` never asserts.
- **Abandon and reset:**
  - Req2 drops valid in ALLOC → IDLE, `rr_ptr` unchanged.
  - `rst_i` during ISSUE → all outputs 0 the next cycle, no ready pulse.

Source files
------------

// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA constants and scheduler types.
package cgra_pkg;
    localparam int N_COL = 4;
    localparam int KER_CONF_N_REG_LOG2 = 5;
    typedef enum logic [1:0] {IDLE, ALLOC, ISSUE, DONE} sched_state_e;
    function automatic int cnt_width(input int n_col);
        return $clog2(n_col + 1);
    endfunction
endpackage

// File: rtl/cgra_rr_arbiter.sv
// cgra_rr_arbiter: picks the first set request at or after ptr_i, wrapping.
module cgra_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    logic [IDX_W-1:0] j;
    // scan from the farthest offset so the nearest request overwrites last
    always_comb begin
        idx_o = '0;
        j = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = IDX_W'((int'(ptr_i) + i) % N_REQ);
            if (req_i[j]) idx_o = j;
        end
    end
    assign any_o = |req_i;
endmodule

// File: rtl/cgra_col_scheduler.sv
// cgra_col_scheduler: round-robin kernel-launch scheduler with first-fit
// contiguous column allocation and a request/ack handshake to the CGRA.
module cgra_col_scheduler #(
    parameter int N_COL = cgra_pkg::N_COL,
    parameter int N_REQ = 4,
    parameter int KER_W = cgra_pkg::KER_CONF_N_REG_LOG2,
    parameter int CNT_W = cgra_pkg::cnt_width(N_COL)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0][KER_W-1:0] req_ker_id_i,
    input  logic [N_REQ-1:0][CNT_W-1:0] req_ncol_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_COL-1:0]            req_cols_o,
    output logic                        req_err_o,
    input  logic [N_COL-1:0]            col_status_i,
    output logic [N_COL-1:0]            acc_req_o,
    output logic [KER_W-1:0]            ker_id_o,
    input  logic                        acc_ack_i,
    output logic                        busy_o
);
    import cgra_pkg::*;

    localparam int IDX_W = N_REQ > 1 ? $clog2(N_REQ) : 1;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] rr_q, rr_d, win_q, win_d, arb_idx;
    logic [KER_W-1:0] kid_q, kid_d;
    logic [CNT_W-1:0] ncol_q, ncol_d;
    logic [N_COL-1:0] mask_q, mask_d, fit, cand;
    logic             err_q, err_d, arb_any, fit_ok, bad_ncol;

    cgra_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign bad_ncol = ncol_q == '0 || int'(ncol_q) > N_COL;

    // descending start scan: the lowest fitting start is written last
    always_comb begin
        fit = '0;
        fit_ok = 1'b0;
        cand = '0;
        for (int s = N_COL - 1; s >= 0; s--) begin
            for (int c = 0; c < N_COL; c++) cand[c] = c >= s && c < s + int'(ncol_q);
            if (s + int'(ncol_q) <= N_COL && (cand & col_status_i) == '0) begin
                fit = cand;
                fit_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d = rr_q;
        win_d = win_q;
        kid_d = kid_q;
        ncol_d = ncol_q;
        mask_d = mask_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (arb_any) begin
                win_d = arb_idx;
                kid_d = req_ker_id_i[arb_idx];
                ncol_d = req_ncol_i[arb_idx];
                state_d = ALLOC;
            end
            ALLOC: if (!req_valid_i[win_q]) begin
                state_d = IDLE;
            end else if (bad_ncol) begin
                mask_d = '0;
                err_d = 1'b1;
                state_d = DONE;
            end else if (fit_ok) begin
                mask_d = fit;
                err_d = 1'b0;
                state_d = ISSUE;
            end
            ISSUE: state_d = acc_ack_i ? DONE : ISSUE;
            DONE: begin
                rr_d = int'(win_q) == N_REQ - 1 ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q <= '0;
            win_q <= '0;
            kid_q <= '0;
            ncol_q <= '0;
            mask_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q <= rr_d;
            win_q <= win_d;
            kid_q <= kid_d;
            ncol_q <= ncol_d;
            mask_q <= mask_d;
            err_q <= err_d;
        end
    end

    assign busy_o = state_q != IDLE;
    assign acc_req_o = state_q == ISSUE ? mask_q : '0;
    assign ker_id_o = state_q == ISSUE ? kid_q : '0;
    assign req_ready_o = state_q == DONE ? N_REQ'(1) << win_q : '0;
    assign req_cols_o = state_q == DONE ? mask_q : '0;
    assign req_err_o = state_q == DONE && err_q;
endmodule
